tlb_op_ctrl: RTL and testbench

//  Sequences the CP0 TLB instructions (TLBP, TLBR, TLBWI, TLBWR) against the shared TLB array.

---
 rtl/tlb_op_ctrl_pkg.sv | 26 ++
 rtl/tlb_op_ctrl_random_gen.sv | 30 +++
 rtl/tlb_op_ctrl.sv | 120 ++++++++++++
 tb/tb_tlb_op_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/tlb_op_ctrl_pkg.sv
// tlb_op_ctrl_pkg: shared op encodings, FSM states, TLB cp0 bus layout and TLB size.
package tlb_op_ctrl_pkg;

    localparam int TLB_NUM_DEF = 16;

    typedef enum logic [1:0] {
        OP_TLBP  = 2'b00,
        OP_TLBR  = 2'b01,
        OP_TLBWI = 2'b10,
        OP_TLBWR = 2'b11
    } tlb_op_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXEC   = 2'd1,
        S_COMMIT = 2'd2,
        S_FLUSH  = 2'd3
    } tlb_state_e;

    // tlb_cp0_bus = {entrylo1, entrylo0, entryhi, pagemask, probe_index}, 32 bits each
    localparam int BUS_W        = 160;
    localparam int PROBE_LSB    = 0;
    localparam int PAGEMASK_LSB = 32;
    localparam int ENTRY_W      = 128;

endpackage

// File: rtl/tlb_op_ctrl_random_gen.sv
// tlb_random_gen: CP0 Random counter, counts down and wraps to TLB_NUM-1 at/below Wired.
//  clk, rst   clock, synchronous active-high reset (Random = TLB_NUM-1)
//  wired      CP0 Wired value (full 32 bits; >= TLB_NUM pins Random at TLB_NUM-1)
//  wired_we   CP0 Wired write this cycle; restarts Random at TLB_NUM-1
//  value      current Random value
module tlb_random_gen #(
    parameter int TLB_NUM = 16,
    parameter int IDX_W   = $clog2(TLB_NUM)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      wired,
    input  logic             wired_we,
    output logic [IDX_W-1:0] value
);

    localparam logic [IDX_W-1:0] TOP = IDX_W'(TLB_NUM - 1);

    logic wrap;

    // The "at or below wired" test also covers a Random that was left below a newly
    // raised Wired, so the counter never walks into the wired region.
    always_comb wrap = wired_we || (wired >= 32'(TLB_NUM)) || (value <= wired[IDX_W-1:0]);

    always_ff @(posedge clk) begin
        if (rst) value <= TOP;
        else     value <= wrap ? TOP : value - IDX_W'(1);
    end

endmodule

// File: rtl/tlb_op_ctrl.sv
// tlb_op_ctrl: sequences TLBP/TLBR/TLBWI/TLBWR against the TLB and writes results back to CP0.
//  clk, rst                               clock, synchronous active-high reset
//  op_valid_i, op_i, op_pc_i, cancel_i    op request from MEM; cancel blocks acceptance
//  op_ready_o, busy_o                     idle / op in flight (pipeline stall)
//  cp0_wired_i, cp0_wired_we_i            CP0 Wired value and write strobe
//  random_o                               CP0 Random, zero-extended
//  tlb_write_index_o, tlb_write_random_o  one-cycle TLB write strobes
//  tlb_cp0_bus_i                          {entrylo1, entrylo0, entryhi, pagemask, probe_index}
//  cp0_index_we_o, cp0_index_wdata_o      TLBP result to CP0 Index
//  cp0_entry_we_o, cp0_entry_wdata_o      TLBR result {entrylo1, entrylo0, entryhi, pagemask}
//  flush_o, flush_pc_o                    one-cycle flush and refetch PC (op PC + 4)
module tlb_op_ctrl
    import tlb_op_ctrl_pkg::*;
#(
    parameter int TLB_NUM = TLB_NUM_DEF,
    parameter int IDX_W   = $clog2(TLB_NUM)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               op_valid_i,
    input  logic [1:0]         op_i,
    input  logic [31:0]        op_pc_i,
    input  logic               cancel_i,
    output logic               op_ready_o,
    output logic               busy_o,
    input  logic [31:0]        cp0_wired_i,
    input  logic               cp0_wired_we_i,
    output logic [31:0]        random_o,
    output logic               tlb_write_index_o,
    output logic               tlb_write_random_o,
    input  logic [BUS_W-1:0]   tlb_cp0_bus_i,
    output logic               cp0_index_we_o,
    output logic [31:0]        cp0_index_wdata_o,
    output logic               cp0_entry_we_o,
    output logic [ENTRY_W-1:0] cp0_entry_wdata_o,
    output logic               flush_o,
    output logic [31:0]        flush_pc_o
);

    tlb_state_e         state, state_nx;
    tlb_op_e            op;
    logic [31:0]        pc;
    logic [31:0]        res_index;
    logic [ENTRY_W-1:0] res_entry;
    logic [IDX_W-1:0]   rnd;
    logic               accept;
    logic               is_write;

    tlb_random_gen #(.TLB_NUM(TLB_NUM), .IDX_W(IDX_W)) u_random (
        .clk      (clk),
        .rst      (rst),
        .wired    (cp0_wired_i),
        .wired_we (cp0_wired_we_i),
        .value    (rnd)
    );

    assign random_o = 32'(rnd);
    assign accept   = (state == S_IDLE) && op_valid_i && !cancel_i;
    assign is_write = (op == OP_TLBWI) || (op == OP_TLBWR);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op        <= OP_TLBP;
            pc        <= '0;
            res_index <= '0;
            res_entry <= '0;
        end else begin
            if (accept) begin
                op <= tlb_op_e'(op_i);
                pc <= op_pc_i;
            end
            if (state == S_EXEC && !is_write) begin
                res_index <= tlb_cp0_bus_i[PROBE_LSB +: 32];
                res_entry <= tlb_cp0_bus_i[PAGEMASK_LSB +: ENTRY_W];
            end
        end
    end

    // Side effects are gated by rst so a reset landing mid-op drops it in that same cycle.
    always_comb begin
        state_nx           = state;
        op_ready_o         = (state == S_IDLE);
        busy_o             = (state != S_IDLE);
        tlb_write_index_o  = 1'b0;
        tlb_write_random_o = 1'b0;
        cp0_index_we_o     = 1'b0;
        cp0_index_wdata_o  = '0;
        cp0_entry_we_o     = 1'b0;
        cp0_entry_wdata_o  = '0;
        flush_o            = 1'b0;
        flush_pc_o         = '0;
        case (state)
            S_IDLE: state_nx = accept ? S_EXEC : S_IDLE;
            S_EXEC: begin
                tlb_write_index_o  = !rst && (op == OP_TLBWI);
                tlb_write_random_o = !rst && (op == OP_TLBWR);
                state_nx           = is_write ? S_FLUSH : S_COMMIT;
            end
            S_COMMIT: begin
                cp0_index_we_o    = !rst && (op == OP_TLBP);
                cp0_index_wdata_o = cp0_index_we_o ? res_index : '0;
                cp0_entry_we_o    = !rst && (op == OP_TLBR);
                cp0_entry_wdata_o = cp0_entry_we_o ? res_entry : '0;
                state_nx          = (op == OP_TLBR) ? S_FLUSH : S_IDLE;
            end
            S_FLUSH: begin
                flush_o    = !rst;
                flush_pc_o = flush_o ? pc + 32'd4 : '0;
                state_nx   = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// tb_tlb_op_ctrl: directed vector table plus hand sequences for tlb_op_ctrl.
module tb_tlb_op_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         op_valid;
    logic [1:0]   op;
    logic [31:0]  op_pc;
    logic         cancel;
    logic         op_ready;
    logic         busy;
    logic [31:0]  wired;
    logic         wired_we;
    logic [31:0]  random_v;
    logic         windex;
    logic         wrandom;
    logic [159:0] bus;
    logic         iwe;
    logic [31:0]  idata;
    logic         ewe;
    logic [127:0] edata;
    logic         flush;
    logic [31:0]  flush_pc;

    always #5 clk = ~clk;

    tlb_op_ctrl dut (
        .clk                (clk),
        .rst                (rst),
        .op_valid_i         (op_valid),
        .op_i               (op),
        .op_pc_i            (op_pc),
        .cancel_i           (cancel),
        .op_ready_o         (op_ready),
        .busy_o             (busy),
        .cp0_wired_i        (wired),
        .cp0_wired_we_i     (wired_we),
        .random_o           (random_v),
        .tlb_write_index_o  (windex),
        .tlb_write_random_o (wrandom),
        .tlb_cp0_bus_i      (bus),
        .cp0_index_we_o     (iwe),
        .cp0_index_wdata_o  (idata),
        .cp0_entry_we_o     (ewe),
        .cp0_entry_wdata_o  (edata),
        .flush_o            (flush),
        .flush_pc_o         (flush_pc)
    );

    typedef struct {
        logic [1:0]   op;
        logic [31:0]  pc;
        logic [31:0]  probe, pm, hi, lo0, lo1;
        int           wi, iw, ew, fl, rdy;
        logic [31:0]  idata;
        logic [127:0] edata;
        logic [31:0]  fpc;
    } vec_t;

    vec_t v[5];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, exp);
        end
    endtask

    task automatic quiet;
        op_valid = 1'b0;
        cancel   = 1'b0;
        wired_we = 1'b0;
    endtask

    // Leaves the bench at a negedge with rst still asserted.
    task automatic do_reset;
        rst = 1'b1;
        quiet();
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        op = 2'b00; op_pc = '0; bus = '0; wired = 32'd4;
        v[0] = '{2'b10, 32'h8000_1000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                 1, -1, -1, 2, 3, 32'h0, 128'h0, 32'h8000_1004};
        v[1] = '{2'b00, 32'h8000_2000, 32'h8000_0000, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444,
                 -1, 2, -1, -1, 3, 32'h8000_0000, 128'h0, 32'h0};
        v[2] = '{2'b00, 32'h8000_3000, 32'h0000_0005, 32'h0, 32'h0, 32'h0, 32'h0,
                 -1, 2, -1, -1, 3, 32'h0000_0005, 128'h0, 32'h0};
        v[3] = '{2'b01, 32'hBFC0_0380, 32'hDEAD_BEEF, 32'h0001_E000, 32'hAAAA_0011, 32'h0000_1F17, 32'h0300_0E07,
                 -1, -1, 2, 3, 4, 32'h0,
                 128'h0300_0E07_0000_1F17_AAAA_0011_0001_E000, 32'hBFC0_0384};
        v[4] = '{2'b10, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                 1, -1, -1, 2, 3, 32'h0, 128'h0, 32'h0000_0000};

        do_reset();
        chk("reset ready", op_ready, 1'b1);
        chk("reset busy", busy, 1'b0);
        chk("reset random", random_v, 32'd15);
        chk("reset strobes", {windex, wrandom, iwe, ewe, flush}, 5'b0);
        chk("reset data", {idata, edata, flush_pc}, 192'h0);

        // Random: Wired=4 gives 15..4 then 15; wired_we restarts; Wired>=16 pins at 15.
        rst = 1'b0;
        for (int k = 0; k <= 14; k++) begin
            chk($sformatf("random k%0d", k), random_v, (k <= 11) ? 15 - k : (k == 12 ? 15 : 27 - k));
            if (k < 14) @(negedge clk);
        end
        wired_we = 1'b1;
        @(negedge clk);
        chk("random after wired_we", random_v, 32'd15);
        wired_we = 1'b0;
        @(negedge clk);
        chk("random after wired_we +1", random_v, 32'd14);
        wired = 32'd20;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("random wired20 k%0d", k), random_v, 32'd15);
        end
        wired = 32'd0;

        // Vector table: op accepted at cycle 0, outputs sampled mid-cycle 1..4.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            op_valid = 1'b1;
            op       = v[i].op;
            op_pc    = v[i].pc;
            bus      = {v[i].lo1, v[i].lo0, v[i].hi, v[i].pm, v[i].probe};
            chk($sformatf("v%0d c0 ready", i), op_ready, 1'b1);
            for (int c = 1; c <= 4; c++) begin
                @(negedge clk);
                op_valid = 1'b0;
                chk($sformatf("v%0d c%0d write_index", i, c), windex, c == v[i].wi);
                chk($sformatf("v%0d c%0d write_random", i, c), wrandom, 1'b0);
                chk($sformatf("v%0d c%0d index_we", i, c), iwe, c == v[i].iw);
                chk($sformatf("v%0d c%0d entry_we", i, c), ewe, c == v[i].ew);
                chk($sformatf("v%0d c%0d flush", i, c), flush, c == v[i].fl);
                chk($sformatf("v%0d c%0d ready", i, c), op_ready, c >= v[i].rdy);
                chk($sformatf("v%0d c%0d busy", i, c), busy, c < v[i].rdy);
                if (c == v[i].iw) chk($sformatf("v%0d index_wdata", i), idata, v[i].idata);
                if (c == v[i].ew) chk($sformatf("v%0d entry_wdata", i), edata, v[i].edata);
                if (c == v[i].fl) chk($sformatf("v%0d flush_pc", i), flush_pc, v[i].fpc);
                if (c == 2) bus = {5{32'h5A5A_A5A5}};
            end
        end

        // TLBWR straight out of reset: Random is 15 in cycle 0, 14 in the EXEC cycle.
        do_reset();
        rst = 1'b0;
        op_valid = 1'b1; op = 2'b11; op_pc = 32'h0000_0100;
        chk("wr c0 random", random_v, 32'd15);
        @(negedge clk);
        op_valid = 1'b0;
        chk("wr c1 write_random", wrandom, 1'b1);
        chk("wr c1 write_index", windex, 1'b0);
        chk("wr c1 random", random_v, 32'd14);
        @(negedge clk);
        chk("wr c2 write_random", wrandom, 1'b0);
        chk("wr c2 flush", flush, 1'b1);
        chk("wr c2 flush_pc", flush_pc, 32'h0000_0104);
        @(negedge clk);
        chk("wr c3 ready", op_ready, 1'b1);

        // Cancel in the request cycle blocks acceptance.
        op_valid = 1'b1; op = 2'b10; cancel = 1'b1;
        @(negedge clk);
        quiet();
        chk("cancel ready", op_ready, 1'b1);
        chk("cancel busy", busy, 1'b0);
        chk("cancel write_index", windex, 1'b0);

        // Cancel after acceptance is ignored.
        op_valid = 1'b1; op = 2'b10; op_pc = 32'h0000_2000;
        @(negedge clk);
        op_valid = 1'b0; cancel = 1'b1;
        #1 chk("late cancel write_index", windex, 1'b1);
        @(negedge clk);
        chk("late cancel flush", flush, 1'b1);
        chk("late cancel flush_pc", flush_pc, 32'h0000_2004);
        quiet();

        // rst during EXEC: no strobe that cycle, idle next, no flush afterwards.
        @(negedge clk);
        op_valid = 1'b1; op = 2'b10; op_pc = 32'h0000_3000;
        @(negedge clk);
        op_valid = 1'b0;
        rst = 1'b1;
        #1 chk("rst exec write_index", windex, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        chk("rst exec ready", op_ready, 1'b1);
        chk("rst exec busy", busy, 1'b0);
        chk("rst exec flush", flush, 1'b0);
        @(negedge clk);
        chk("rst exec flush later", flush, 1'b0);
        chk("rst exec write_index later", windex, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
